// File: rtl/wb_register_file_if.sv
// rtl/wb_register_file_if.sv - writeback commit and register read bus between MEM/WB, ID and the register file
interface wb_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  reg_write;
    logic [31:0]           write_register;
    logic [DATA_WIDTH-1:0] write_data;
    logic [ADDR_WIDTH-1:0] read_addr_a;
    logic [ADDR_WIDTH-1:0] read_addr_b;
    logic [DATA_WIDTH-1:0] read_data_a;
    logic [DATA_WIDTH-1:0] read_data_b;
    logic [31:0]           commit_count;
    logic                  last_commit_valid;
    logic [ADDR_WIDTH-1:0] last_commit_addr;
    logic [DATA_WIDTH-1:0] last_commit_data;

    modport master (
        output reg_write, write_register, write_data, read_addr_a, read_addr_b,
        input  read_data_a, read_data_b, commit_count, last_commit_valid,
               last_commit_addr, last_commit_data
    );

    modport slave (
        input  reg_write, write_register, write_data, read_addr_a, read_addr_b,
        output read_data_a, read_data_b, commit_count, last_commit_valid,
               last_commit_addr, last_commit_data
    );
endinterface

// File: rtl/wb_register_file.sv
// rtl/wb_register_file.sv - architectural register file with writeback bypass and commit trace
module wb_register_file #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    wb_register_file_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [31:0]           commit_count_q, commit_count_d;
    logic                  last_valid_q, last_valid_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [DATA_WIDTH-1:0] last_data_q, last_data_d;

    logic [ADDR_WIDTH-1:0] widx;
    logic                  accept;

    // Upper index bits from MEM/WB carry no meaning here and are discarded.
    logic unused_write_register_hi;
    assign unused_write_register_hi = ^bus.write_register[31:ADDR_WIDTH];

    assign widx = bus.write_register[ADDR_WIDTH-1:0];

    // Gating with reset keeps the bypass from leaking a value while the file is held cleared.
    assign accept = bus.reg_write && rst_n_i && !(ZERO_REG_EN && (widx == '0));

    // Next state of the commit trace: advances only on an accepted write.
    always_comb begin
        commit_count_d = commit_count_q;
        last_valid_d   = last_valid_q;
        last_addr_d    = last_addr_q;
        last_data_d    = last_data_q;
        if (accept) begin
            commit_count_d = commit_count_q + 32'd1;
            last_valid_d   = 1'b1;
            last_addr_d    = widx;
            last_data_d    = bus.write_data;
        end
    end

    // Register array and commit trace state with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            commit_count_q <= '0;
            last_valid_q   <= 1'b0;
            last_addr_q    <= '0;
            last_data_q    <= '0;
        end else begin
            if (accept) begin
                regs_q[widx] <= bus.write_data;
            end
            commit_count_q <= commit_count_d;
            last_valid_q   <= last_valid_d;
            last_addr_q    <= last_addr_d;
            last_data_q    <= last_data_d;
        end
    end

    // Read port A: hardwired zero, then same-cycle bypass, then stored entry.
    always_comb begin
        bus.read_data_a = regs_q[bus.read_addr_a];
        if (ZERO_REG_EN && (bus.read_addr_a == '0)) begin
            bus.read_data_a = '0;
        end else if (accept && (widx == bus.read_addr_a)) begin
            bus.read_data_a = bus.write_data;
        end
    end

    // Read port B: same priority as port A, fully independent.
    always_comb begin
        bus.read_data_b = regs_q[bus.read_addr_b];
        if (ZERO_REG_EN && (bus.read_addr_b == '0)) begin
            bus.read_data_b = '0;
        end else if (accept && (widx == bus.read_addr_b)) begin
            bus.read_data_b = bus.write_data;
        end
    end

    assign bus.commit_count      = commit_count_q;
    assign bus.last_commit_valid = last_valid_q;
    assign bus.last_commit_addr  = last_addr_q;
    assign bus.last_commit_data  = last_data_q;
endmodule

// File: tb/tb_wb_register_file.sv
// tb/tb_wb_register_file.sv - scoreboard bench for wb_register_file
module tb_wb_register_file;
    logic clk;
    logic rst_n;

    wb_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    wb_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG_EN(1'b1)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } rd_exp_t;

    typedef struct {
        logic [31:0] cnt;
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
    } st_exp_t;

    rd_exp_t     rd_q[$];
    st_exp_t     st_q[$];
    logic [31:0] mdl [32];
    logic [31:0] m_cnt;
    logic        m_valid;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          n_vec;
    int          n_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        m_cnt   = 32'h0;
        m_valid = 1'b0;
        m_addr  = 5'h0;
        m_data  = 32'h0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] ra, input logic acc,
                                               input logic [4:0] idx, input logic [31:0] wd);
        if (ra == 5'd0) return 32'h0;
        if (acc && idx == ra) return wd;
        return mdl[ra];
    endfunction

    // One clock of stimulus, entered and left on a falling edge.
    task automatic cycle(input logic we, input logic [31:0] widx, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb, input string tag);
        logic       acc;
        logic [4:0] idx;
        rd_exp_t    r;
        st_exp_t    s;
        idx = widx[4:0];
        acc = we && (idx != 5'd0);
        bus.reg_write      = we;
        bus.write_register = widx;
        bus.write_data     = wd;
        bus.read_addr_a    = ra;
        bus.read_addr_b    = rb;
        r.a = model_read(ra, acc, idx, wd);
        r.b = model_read(rb, acc, idx, wd);
        rd_q.push_back(r);
        if (acc) begin
            mdl[idx] = wd;
            m_cnt    = m_cnt + 32'd1;
            m_valid  = 1'b1;
            m_addr   = idx;
            m_data   = wd;
        end
        s.cnt   = m_cnt;
        s.valid = m_valid;
        s.addr  = {27'h0, m_addr};
        s.data  = m_data;
        st_q.push_back(s);
        #2;
        r = rd_q.pop_front();
        check_eq({tag, ".rda"}, bus.read_data_a, r.a);
        check_eq({tag, ".rdb"}, bus.read_data_b, r.b);
        @(posedge clk);
        #1;
        s = st_q.pop_front();
        check_eq({tag, ".cnt"}, bus.commit_count, s.cnt);
        check_eq({tag, ".lvalid"}, {31'h0, bus.last_commit_valid}, {31'h0, s.valid});
        check_eq({tag, ".laddr"}, {27'h0, bus.last_commit_addr}, s.addr);
        check_eq({tag, ".ldata"}, bus.last_commit_data, s.data);
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        rst_n = 1'b0;
        bus.reg_write      = 1'b0;
        bus.write_register = 32'h0;
        bus.write_data     = 32'h0;
        bus.read_addr_a    = 5'd0;
        bus.read_addr_b    = 5'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        cycle(1'b0, 32'd0, 32'h0, 5'd5, 5'd31, "reset");
        cycle(1'b1, 32'd5, 32'hDEADBEEF, 5'd1, 5'd2, "wr5");
        cycle(1'b0, 32'd0, 32'h0, 5'd5, 5'd5, "rd5");
        cycle(1'b1, 32'd7, 32'h12345678, 5'd7, 5'd7, "byp7");
        cycle(1'b1, 32'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "zero");
        cycle(1'b1, 32'h23, 32'h000000A5, 5'd5, 5'd3, "trunc");
        cycle(1'b0, 32'd3, 32'h0BADF00D, 5'd3, 5'd7, "nowe");
        cycle(1'b1, 32'd9, 32'h11111111, 5'd9, 5'd3, "b2b1");
        cycle(1'b1, 32'd9, 32'h22222222, 5'd9, 5'd0, "b2b2");
        cycle(1'b0, 32'd0, 32'h0, 5'd9, 5'd31, "b2brd");

        for (int i = 0; i < 40; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rand");
        end

        // Counter wrap: preload the count just below rollover.
        force dut.commit_count_q = 32'hFFFFFFFF;
        #1;
        release dut.commit_count_q;
        m_cnt = 32'hFFFFFFFF;
        cycle(1'b1, 32'd12, 32'hCAFEF00D, 5'd12, 5'd5, "wrap");

        // Asynchronous reset in the middle of a cycle with a write pending.
        cycle(1'b1, 32'd4, 32'h44444444, 5'd4, 5'd5, "prerst");
        bus.reg_write      = 1'b1;
        bus.write_register = 32'd9;
        bus.write_data     = 32'h55555555;
        bus.read_addr_a    = 5'd9;
        bus.read_addr_b    = 5'd4;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst.rda", bus.read_data_a, 32'h0);
        check_eq("rst.rdb", bus.read_data_b, 32'h0);
        check_eq("rst.cnt", bus.commit_count, m_cnt);
        check_eq("rst.lvalid", {31'h0, bus.last_commit_valid}, 32'h0);
        @(posedge clk);
        #1;
        check_eq("rsthold.cnt", bus.commit_count, m_cnt);
        check_eq("rsthold.rda", bus.read_data_a, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 32'd9, 32'h55555555, 5'd4, 5'd9, "relwr");
        cycle(1'b0, 32'd0, 32'h0, 5'd9, 5'd5, "relrd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
